// File: rtl/pwm_peripheral.sv
// 16-channel PWM output stage: shared prescaler, 8-bit period counter and
// period-shadowed duty cycle, with per-channel off / static-on / PWM selection.
module pwm_peripheral #(
    parameter int PRESCALE = 39
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] en_reg_out_7_0,
    input  logic [7:0] en_reg_out_15_8,
    input  logic [7:0] en_reg_pwm_7_0,
    input  logic [7:0] en_reg_pwm_15_8,
    input  logic [7:0] pwm_duty_cycle,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic       pwm_sync
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic [15:0] presc_q, presc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  duty_active_q, duty_active_d;
    logic [15:0] out_q, out_d;
    logic        pwm_sync_q, pwm_sync_d;

    logic        tick;
    logic        period_start;
    logic [7:0]  duty_eff;
    logic        pwm_raw;
    logic [15:0] en_out;
    logic [15:0] en_pwm;

    // Full-scale duty must hold the output high for the whole period,
    // which a plain cnt < duty compare cannot express.
    function automatic logic pwm_level(input logic [7:0] cnt, input logic [7:0] duty);
        return (duty == 8'hFF) ? 1'b1 : (cnt < duty);
    endfunction

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    always_comb begin
        tick          = (presc_q == PRESC_LAST);
        period_start  = (presc_q == 16'd0) && (cnt_q == 8'd0);
        presc_d       = tick ? 16'd0 : presc_q + 16'd1;
        cnt_d         = tick ? cnt_q + 8'd1 : cnt_q;
        // The first slot of a period already uses the freshly sampled duty.
        duty_eff      = period_start ? pwm_duty_cycle : duty_active_q;
        duty_active_d = duty_eff;
        pwm_raw       = pwm_level(cnt_q, duty_eff);
        out_d         = en_out & (~en_pwm | {16{pwm_raw}});
        pwm_sync_d    = period_start;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q       <= 16'd0;
            cnt_q         <= 8'd0;
            duty_active_q <= 8'd0;
            out_q         <= 16'd0;
            pwm_sync_q    <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            cnt_q         <= cnt_d;
            duty_active_q <= duty_active_d;
            out_q         <= out_d;
            pwm_sync_q    <= pwm_sync_d;
        end
    end

    assign uo_out   = out_q[7:0];
    assign uio_out  = out_q[15:8];
    assign pwm_sync = pwm_sync_q;

endmodule
